// File: rtl/logic_gate_identifier.sv
// logic_gate_identifier: probes a hidden-opcode gate unit with all four
// operand patterns, double-samples each result, rebuilds the truth table
// and decodes it back to the 3-bit opcode.

module logic_gate_identifier #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_result,
  output logic [1:0] probe_ab,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] opcode,
  output logic       valid,
  output logic       unknown,
  output logic       unstable
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE_A,
    SAMPLE_B,
    DECODE,
    DONE
  } state_e;

  // Terminal count of the settle counter; SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] tt_q, tt_d;
  logic       unstable_q, unstable_d;
  logic [2:0] opcode_q, opcode_d;
  logic       valid_q, valid_d;
  logic       unknown_q, unknown_d;

  logic [2:0] decOp;
  logic       decKnown;

  // State and datapath registers; synchronous active-low reset aborts any sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      tt_q       <= '0;
      unstable_q <= 1'b0;
      opcode_q   <= '0;
      valid_q    <= 1'b0;
      unknown_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tt_q       <= tt_d;
      unstable_q <= unstable_d;
      opcode_q   <= opcode_d;
      valid_q    <= valid_d;
      unknown_q  <= unknown_d;
    end
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = SETTLE;
      SETTLE:   if (cnt_q == SettleLast) state_d = SAMPLE_A;
      SAMPLE_A: state_d = SAMPLE_B;
      SAMPLE_B: state_d = (idx_q == 2'd3) ? DECODE : SETTLE;
      DECODE:   state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Map a captured truth table (bit i = result for probe i) to its opcode.
  always_comb begin
    decOp    = 3'd0;
    decKnown = 1'b1;
    unique case (tt_q)
      4'b0101: decOp = 3'd0;
      4'b1010: decOp = 3'd1;
      4'b1001: decOp = 3'd2;
      4'b0110: decOp = 3'd3;
      4'b1110: decOp = 3'd4;
      4'b0001: decOp = 3'd5;
      4'b1000: decOp = 3'd6;
      4'b0111: decOp = 3'd7;
      default: decKnown = 1'b0;
    endcase
  end

  // Datapath updates: clear on accepted start, count settle time, capture and
  // re-check samples, and publish the decode result on the way into DONE.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tt_d       = tt_q;
    unstable_d = unstable_q;
    opcode_d   = opcode_q;
    valid_d    = valid_q;
    unknown_d  = unknown_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d      = '0;
          idx_d      = '0;
          tt_d       = '0;
          unstable_d = 1'b0;
          opcode_d   = '0;
          valid_d    = 1'b0;
          unknown_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q != SettleLast) cnt_d = cnt_q + 8'd1;
      end
      SAMPLE_A: begin
        tt_d[idx_q] = gate_result;
      end
      SAMPLE_B: begin
        if (gate_result != tt_q[idx_q]) unstable_d = 1'b1;
        if (idx_q != 2'd3) begin
          idx_d = idx_q + 2'd1;
          cnt_d = '0;
        end
      end
      DECODE: begin
        idx_d = '0;
        if (unstable_q) begin
          opcode_d  = '0;
          valid_d   = 1'b0;
          unknown_d = 1'b0;
        end else if (decKnown) begin
          opcode_d  = decOp;
          valid_d   = 1'b1;
          unknown_d = 1'b0;
        end else begin
          opcode_d  = '0;
          valid_d   = 1'b0;
          unknown_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Moore outputs derived from the current state and held registers.
  always_comb begin
    probe_ab    = idx_q;
    busy        = (state_q == SETTLE) || (state_q == SAMPLE_A) ||
                  (state_q == SAMPLE_B) || (state_q == DECODE);
    done        = (state_q == DONE);
    truth_table = tt_q;
    opcode      = opcode_q;
    valid       = valid_q;
    unknown     = unknown_q;
    unstable    = unstable_q;
  end

endmodule

// File: tb/tb_logic_gate_identifier.sv
// tb_logic_gate_identifier: directed bench with a gate-unit model and a
// scoreboard of expected sweep results.

module tb_logic_gate_identifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       gateResult;
  logic [1:0] probeAb;
  logic       busy, done;
  logic [3:0] truthTable;
  logic [2:0] opcode;
  logic       valid, unknown, unstable;

  logic       start2 = 1'b0;
  logic       gateResult2;
  logic [1:0] probeAb2;
  logic       busy2, done2;
  logic [3:0] truthTable2;
  logic [2:0] opcode2;
  logic       valid2, unknown2, unstable2;

  // Model control: 0 = gate with modelOp, 1 = constant 1, 2 = gate with glitch
  logic [1:0] modelMode = 2'd0;
  logic [2:0] modelOp = 3'd0;
  int         edgeCnt = 0;
  int         startEdge = 0;
  logic [3:0] pipe = 4'd0;
  logic       glitch;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] tt;
    logic [2:0] flags;
    int         doneRel;
  } exp_t;
  exp_t sbQ[$];

  logic_gate_identifier #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_result(gateResult),
    .probe_ab(probeAb), .busy(busy), .done(done), .truth_table(truthTable),
    .opcode(opcode), .valid(valid), .unknown(unknown), .unstable(unstable)
  );

  logic_gate_identifier #(.SETTLE_CYCLES(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_result(gateResult2),
    .probe_ab(probeAb2), .busy(busy2), .done(done2), .truth_table(truthTable2),
    .opcode(opcode2), .valid(valid2), .unknown(unknown2), .unstable(unstable2)
  );

  always #5 clk = ~clk;

  // Reference gate unit: a = ab[0], b = ab[1].
  function automatic logic gateFn(input logic [2:0] op, input logic [1:0] ab);
    logic a, b;
    a = ab[0];
    b = ab[1];
    case (op)
      3'd0: return ~a;
      3'd1: return a;
      3'd2: return ~(a ^ b);
      3'd3: return a ^ b;
      3'd4: return a | b;
      3'd5: return ~(a | b);
      3'd6: return a & b;
      default: return ~(a & b);
    endcase
  endfunction

  // Absolute edge counter used for latency and glitch timing.
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Glitch lands in the SAMPLE_B cycle of pattern 2 (relative edge 12 to 13).
  assign glitch = (modelMode == 2'd2) && (edgeCnt == startEdge + 11);
  assign gateResult = (modelMode == 2'd1) ? 1'b1 : (gateFn(modelOp, probeAb) ^ glitch);

  // NAND gate unit with a four-cycle result delay for the slow instance.
  always @(posedge clk) pipe <= {pipe[2:0], gateFn(3'd7, probeAb2)};
  assign gateResult2 = pipe[3];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse with the given model setup and queue the expected result.
  task automatic applyStimulus(input logic [1:0] mode, input logic [2:0] op);
    exp_t e;
    @(negedge clk);
    modelMode = mode;
    modelOp   = op;
    start     = 1'b1;
    startEdge = edgeCnt + 1;
    e.doneRel = 18;
    for (int i = 0; i < 4; i++) e.tt[i] = (mode == 2'd1) ? 1'b1 : gateFn(op, 2'(i));
    if (mode == 2'd1) begin
      e.op = 3'd0;
      e.flags = 3'b010;
    end else if (mode == 2'd2) begin
      e.op = 3'd0;
      e.flags = 3'b001;
    end else begin
      e.op = op;
      e.flags = 3'b100;
    end
    sbQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then pop and compare against the scoreboard.
  task automatic waitDone(input string tag);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, " done seen"}, 32'(seen), 32'd1);
    e = sbQ.pop_front();
    if (seen) begin
      checkOutput({tag, " done edge"}, 32'(edgeCnt - startEdge + 1), 32'(e.doneRel));
      checkOutput({tag, " opcode"}, 32'(opcode), 32'(e.op));
      checkOutput({tag, " truth_table"}, 32'(truthTable), 32'(e.tt));
      checkOutput({tag, " flags"}, 32'({valid, unknown, unstable}), 32'(e.flags));
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    int de[3];
    int n;
    bit seen2;

    // Reset both instances and check the idle output state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset outputs",
                32'({probeAb, busy, done, truthTable, opcode, valid, unknown, unstable}), 32'd0);

    // Sweep every opcode against the gate model.
    for (int op = 0; op < 8; op++) begin
      applyStimulus(2'd0, 3'(op));
      checkOutput("busy after start", 32'(busy), 32'd1);
      waitDone($sformatf("op%0d", op));
    end

    // Hard-coded reference for AND.
    applyStimulus(2'd0, 3'd6);
    waitDone("and");
    checkOutput("and table literal", 32'(truthTable), 32'b1000);

    // Constant-1 result matches no gate.
    applyStimulus(2'd1, 3'd0);
    waitDone("const1");

    // XOR with a glitch during the second sample of pattern 2.
    applyStimulus(2'd2, 3'd3);
    waitDone("glitch");

    // Reset during SETTLE of pattern 2 aborts the sweep without done.
    applyStimulus(2'd0, 3'd6);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid reset outputs",
                32'({probeAb, busy, done, truthTable, opcode, valid, unknown, unstable}), 32'd0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    checkOutput("no done after abort", 32'(cnt), 32'd0);
    void'(sbQ.pop_back());
    applyStimulus(2'd0, 3'd6);
    waitDone("after reset");

    // start re-asserted at relative edge 5 is ignored.
    applyStimulus(2'd0, 3'd4);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("retrigger");
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    checkOutput("single done", 32'(cnt), 32'd0);

    // start held high: back-to-back sweeps every 19 cycles.
    @(negedge clk);
    modelMode = 2'd0;
    modelOp = 3'd4;
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 80 && n < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        de[n] = edgeCnt;
        n++;
      end
    end
    start = 1'b0;
    checkOutput("held pulses", 32'(n), 32'd3);
    if (n == 3) begin
      checkOutput("held period 1", 32'(de[1] - de[0]), 32'd19);
      checkOutput("held period 2", 32'(de[2] - de[1]), 32'd19);
    end
    repeat (25) @(negedge clk);

    // Slow instance: SETTLE_CYCLES=5 against a delayed NAND.
    @(negedge clk);
    start2 = 1'b1;
    startEdge = edgeCnt + 1;
    @(negedge clk);
    start2 = 1'b0;
    seen2 = 1'b0;
    for (int i = 0; i < 80 && !seen2; i++) begin
      @(negedge clk);
      if (done2 === 1'b1) seen2 = 1'b1;
    end
    checkOutput("slow done seen", 32'(seen2), 32'd1);
    if (seen2) begin
      checkOutput("slow done edge", 32'(edgeCnt - startEdge + 1), 32'd30);
      checkOutput("slow opcode", 32'(opcode2), 32'd7);
      checkOutput("slow truth_table", 32'(truthTable2), 32'b0111);
      checkOutput("slow flags", 32'({valid2, unknown2, unstable2}), 32'b100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
